pc_fetch_gen: RTL and testbench
===============================

// Module: pc_fetch_gen
// PURPOSE
//  Next-generation program-counter generator for the fetch stage: owns the PC register,
//  computes branch/JAL (PC+imm) and JALR ((rs1+imm)&~1) targets, checks target alignment,
//  and drives a valid/ready fetch request to the instruction cache. Redirects arriving
//  while the cache holds a request are buffered in a one-entry pending register.
// PARAMETERS
//  XLEN          32            address/data width in bits
//  RESET_VECTOR  32'h0000_0000 PC value loaded at reset
//  IALIGN        32            instruction alignment: 32 (checks bits[1:0]) or 16 (checks bit[0])
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst_n           in   1     asynchronous active-low reset
//  stall_i         in   1     pipeline hazard stall; blocks raising a new request
//  redir_valid_i   in   1     redirect strobe from execute, one cycle
//  redir_mode_i    in   1     0: base_pc+imm (branch/JAL), 1: (rs1+imm)&~1 (JALR)
//  redir_pc_i      in   XLEN  PC of redirecting instruction
//  redir_rs1_i     in   XLEN  rs1 value for JALR
//  redir_imm_i     in   XLEN  sign-extended immediate
//  if_req_valid_o  out  1     fetch request valid to I-cache
//  if_req_addr_o   out  XLEN  fetch address (== pc_o)
//  if_req_ready_i  in   1     I-cache accepts request
//  pc_o            out  XLEN  current PC register
//  pc_plus4_o      out  XLEN  pc_o + 4 (link value)
//  target_o        out  XLEN  combinational redirect target
//  pending_o       out  1     redirect buffered, not yet applied
//  misalign_o      out  1     one-cycle pulse: redirect dropped, target misaligned
// BEHAVIOUR
//  Reset: pc=RESET_VECTOR, if_req_valid_o=0, pending_o=0, misalign_o=0, state=IDLE.
//  States: IDLE -> RUN on first clock after reset release (unconditional).
//   RUN: no redirect buffered. RUN -> PEND on redirect while request held (valid&!ready).
//   PEND -> RUN when held request is accepted; PC loads buffered target.
//  Arithmetic: all adds modulo 2^XLEN (wrap silently); mode 1 clears bit 0 of sum.
//  Alignment: misaligned if target[1:0]!=0 (IALIGN=32) or target[0]!=0 (IALIGN=16);
//   misaligned redirect is dropped (no PC/pending change), misalign_o=1 next cycle.
//  Request: valid rises in RUN/PEND when !stall_i; once high, valid and addr stay
//   stable until valid&ready, regardless of stall_i or redirect (no retraction).
//  Accept (valid&ready) cycle, next PC priority: aligned redirect this cycle >
//   pending target > pc+4. Valid stays high next cycle unless stall_i.
//  Redirect with no held request (valid=0 or accepted same cycle): applied to PC
//   next cycle, pending_o stays 0.
//  Redirect while in PEND: new target overwrites buffered one (youngest wins).
//  stall_i with valid=0: PC holds, valid stays 0; redirect still applied to PC.
//  Latency: redirect -> if_req_addr_o = target one cycle later when not blocked.
//  Reset mid-operation: async clear to reset values, pending target discarded.
// TESTING
//  1 Reset release, ready=1 always -> addr 0x0,0x4,0x8,... one per cycle from cycle 1.
//  2 pc=0x100, redirect mode0 imm=0xFFFFFFF0 -> next addr 0xF0; pc=0xFFFFFFFC,
//    imm=8 -> addr 0x4 (wrap).
//  3 mode1 rs1=0x2001, imm=0x2 -> target 0x2002 (IALIGN=32): dropped, misalign_o pulse,
//    PC continues; same with IALIGN=16 -> accepted, addr 0x2002.
//  4 ready=0 holding 0x40, redirect to 0x80 -> addr stays 0x40, pending_o=1; ready=1
//    -> next addr 0x80, pending_o=0.
//  5 In PEND (0x80), second redirect to 0xC0 -> on accept next addr 0xC0.
//  6 stall_i=1 with valid high & ready=0 -> valid holds; rst_n low mid-PEND -> valid=0,
//    pc=RESET_VECTOR, pending_o=0 immediately.

Source files
------------

// File: rtl/pc_fetch_gen.sv
// Fetch-stage program-counter generator: PC register, redirect target and alignment
// check, valid/ready I-cache request with a one-entry pending-redirect buffer.
module pc_fetch_gen #(
  parameter int unsigned         XLEN         = 32,
  parameter logic [XLEN-1:0]     RESET_VECTOR = '0,
  parameter int unsigned         IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            redir_valid_i,
  input  logic            redir_mode_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic [XLEN-1:0] redir_rs1_i,
  input  logic [XLEN-1:0] redir_imm_i,
  output logic            if_req_valid_o,
  output logic [XLEN-1:0] if_req_addr_o,
  input  logic            if_req_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] target_o,
  output logic            pending_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            valid_q, valid_d;
  logic            pending_q, pending_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            misaligned;
  logic            redir_ok;
  logic            accept;
  logic            held;

  always_comb begin
    sum      = (redir_mode_i ? redir_rs1_i : redir_pc_i) + redir_imm_i;
    target   = redir_mode_i ? {sum[XLEN-1:1], 1'b0} : sum;
    pc_plus4 = pc_q + XLEN'(4);
    if (IALIGN == 16) misaligned = target[0];
    else              misaligned = (target[1:0] != 2'b00);
    redir_ok = redir_valid_i && !misaligned;
    accept   = valid_q && if_req_ready_i;
    held     = valid_q && !if_req_ready_i;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    valid_d    = valid_q;
    misalign_d = redir_valid_i && misaligned;
    unique case (state_q)
      IDLE: begin
        state_d = RUN;
        valid_d = 1'b0;
        if (redir_ok) pc_d = target;
      end
      default: begin
        if (accept) begin
          // Priority on accept: fresh redirect, then buffered target, then sequential.
          if (redir_ok)             pc_d = target;
          else if (state_q == PEND) pc_d = pend_tgt_q;
          else                      pc_d = pc_plus4;
          state_d = RUN;
          valid_d = !stall_i;
        end else if (held) begin
          // Request must not be retracted; buffer the redirect (youngest wins).
          if (redir_ok) begin
            pend_tgt_d = target;
            state_d    = PEND;
          end
        end else begin
          if (redir_ok) pc_d = target;
          valid_d = !stall_i;
        end
      end
    endcase
    pending_d = (state_d == PEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      pend_tgt_q <= '0;
      valid_q    <= 1'b0;
      pending_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      valid_q    <= valid_d;
      pending_q  <= pending_d;
      misalign_q <= misalign_d;
    end
  end

  assign if_req_valid_o = valid_q;
  assign if_req_addr_o  = pc_q;
  assign pc_o           = pc_q;
  assign pc_plus4_o     = pc_plus4;
  assign target_o       = target;
  assign pending_o      = pending_q;
  assign misalign_o     = misalign_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Bench for pc_fetch_gen: IALIGN=32 and IALIGN=16 instances share stimulus; vector table
// plus hand sequences for hold/pending, stall and asynchronous reset.
module tb_pc_fetch_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redir_valid_i;
  logic        redir_mode_i;
  logic [31:0] redir_pc_i, redir_rs1_i, redir_imm_i;
  logic        if_req_ready_i;

  logic        valid32, pend32, mis32;
  logic [31:0] addr32, pc32, pc4_32, tgt32;
  logic        valid16, pend16, mis16;
  logic [31:0] addr16, pc16, pc4_16, tgt16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .redir_valid_i(redir_valid_i), .redir_mode_i(redir_mode_i),
    .redir_pc_i(redir_pc_i), .redir_rs1_i(redir_rs1_i), .redir_imm_i(redir_imm_i),
    .if_req_valid_o(valid32), .if_req_addr_o(addr32), .if_req_ready_i(if_req_ready_i),
    .pc_o(pc32), .pc_plus4_o(pc4_32), .target_o(tgt32),
    .pending_o(pend32), .misalign_o(mis32)
  );

  pc_fetch_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
    .redir_valid_i(redir_valid_i), .redir_mode_i(redir_mode_i),
    .redir_pc_i(redir_pc_i), .redir_rs1_i(redir_rs1_i), .redir_imm_i(redir_imm_i),
    .if_req_valid_o(valid16), .if_req_addr_o(addr16), .if_req_ready_i(if_req_ready_i),
    .pc_o(pc16), .pc_plus4_o(pc4_16), .target_o(tgt16),
    .pending_o(pend16), .misalign_o(mis16)
  );

  typedef struct {
    logic        redir;
    logic        mode;
    logic [31:0] bpc, rs1, imm;
    logic [31:0] tgt;
    logic [31:0] addr32;
    logic        mis32;
    logic [31:0] addr16;
    logic        mis16;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] addr32;
    logic        mis32;
    logic        pend;
    logic [31:0] addr16;
    logic        mis16;
  } exp_t;

  vec_t vecs[7];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rv, input logic md, input logic [31:0] bpc,
                       input logic [31:0] rs1, input logic [31:0] imm);
    redir_valid_i = rv;
    redir_mode_i  = md;
    redir_pc_i    = bpc;
    redir_rs1_i   = rs1;
    redir_imm_i   = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard_empty actual=0 expected=1", name);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_valid"}, {31'b0, valid32}, {31'b0, e.valid});
      chk({name, "_addr32"}, addr32, e.addr32);
      chk({name, "_mis32"}, {31'b0, mis32}, {31'b0, e.mis32});
      chk({name, "_pend"}, {31'b0, pend32}, {31'b0, e.pend});
      chk({name, "_addr16"}, addr16, e.addr16);
      chk({name, "_mis16"}, {31'b0, mis16}, {31'b0, e.mis16});
    end
  endtask

  initial begin
    //          redir mode bpc           rs1           imm           tgt           addr32        m32   addr16        m16
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'hFFFF_FFF0, 32'h0000_00F0, 32'h0000_00F0, 1'b0, 32'h0000_00F0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0000_0008, 32'h0000_0004, 32'h0000_0004, 1'b0, 32'h0000_0004, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h0,        32'h0000_2001, 32'h0000_0002, 32'h0000_2002, 32'h0000_0008, 1'b1, 32'h0000_2002, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0000_000C, 1'b0, 32'h0000_2006, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h0,        32'h0000_1000, 32'h0000_0005, 32'h0000_1004, 32'h0000_1004, 1'b0, 32'h0000_1004, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        32'h0000_0002, 32'h0000_0042, 32'h0000_1008, 1'b1, 32'h0000_0042, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0,        32'h0,        32'h0000_0040, 32'h0000_0040, 32'h0000_0040, 1'b0, 32'h0000_0040, 1'b0};

    rst_n = 1'b0;
    stall_i = 1'b0;
    if_req_ready_i = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    #3;
    chk("rst_valid", {31'b0, valid32}, 32'h0);
    chk("rst_pc", pc32, 32'h0);
    chk("rst_pend", {31'b0, pend32}, 32'h0);
    chk("rst_mis", {31'b0, mis32}, 32'h0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // sequential fetch: bounded wait for the first request
    begin
      int n = 0;
      step();
      while (!valid32 && n < 5) begin
        step();
        n++;
      end
      chk("first_req_valid", {31'b0, valid32}, 32'h1);
    end
    chk("seq_addr0", addr32, 32'h0);
    chk("pc_plus4", pc4_32, 32'h4);
    for (int unsigned i = 1; i <= 4; i++) begin
      exp_q.push_back('{1'b1, 32'(i * 4), 1'b0, 1'b0, 32'(i * 4), 1'b0});
      @(negedge clk);
      step();
      pop_check("seq");
    end

    // redirect vector table, ready=1 stall=0 throughout
    for (int unsigned i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].redir, vecs[i].mode, vecs[i].bpc, vecs[i].rs1, vecs[i].imm);
      #1;
      if (vecs[i].redir) begin
        chk($sformatf("vec%0d_target32", i), tgt32, vecs[i].tgt);
        chk($sformatf("vec%0d_target16", i), tgt16, vecs[i].tgt);
      end
      exp_q.push_back('{1'b1, vecs[i].addr32, vecs[i].mis32, 1'b0, vecs[i].addr16, vecs[i].mis16});
      step();
      pop_check($sformatf("vec%0d", i));
    end

    // hold 0x40, redirect to 0x80 buffered, applied on accept
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0); if_req_ready_i = 1'b0;
    exp_q.push_back('{1'b1, 32'h40, 1'b0, 1'b0, 32'h40, 1'b0});
    step(); pop_check("hold40");
    @(negedge clk); drive(1'b1, 1'b0, 32'h80, '0, '0);
    exp_q.push_back('{1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 1'b0});
    step(); pop_check("pend80");
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0); if_req_ready_i = 1'b1;
    exp_q.push_back('{1'b1, 32'h80, 1'b0, 1'b0, 32'h80, 1'b0});
    step(); pop_check("accept80");

    // two redirects while pending: youngest wins
    @(negedge clk); if_req_ready_i = 1'b0; drive(1'b1, 1'b0, 32'h100, '0, '0);
    exp_q.push_back('{1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 1'b0});
    step(); pop_check("pend100");
    @(negedge clk); drive(1'b1, 1'b0, 32'hC0, '0, '0);
    exp_q.push_back('{1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 1'b0});
    step(); pop_check("pendC0");
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0); if_req_ready_i = 1'b1;
    exp_q.push_back('{1'b1, 32'hC0, 1'b0, 1'b0, 32'hC0, 1'b0});
    step(); pop_check("acceptC0");

    // stall with request held: no retraction; then async reset mid-PEND
    @(negedge clk); if_req_ready_i = 1'b0; stall_i = 1'b1;
    exp_q.push_back('{1'b1, 32'hC0, 1'b0, 1'b0, 32'hC0, 1'b0});
    step(); pop_check("stall_hold");
    @(negedge clk); drive(1'b1, 1'b0, 32'h200, '0, '0);
    exp_q.push_back('{1'b1, 32'hC0, 1'b0, 1'b1, 32'hC0, 1'b0});
    step(); pop_check("stall_pend");
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'b0, valid32}, 32'h0);
    chk("async_rst_pc", pc32, 32'h0);
    chk("async_rst_pend", {31'b0, pend32}, 32'h0);

    // stall with no request: PC holds, redirect still lands, valid rises on unstall
    @(negedge clk); rst_n = 1'b1; if_req_ready_i = 1'b1;
    step(); step(); step();
    chk("stall_idle_valid", {31'b0, valid32}, 32'h0);
    chk("stall_idle_pc", pc32, 32'h0);
    @(negedge clk); drive(1'b1, 1'b0, 32'h300, '0, '0);
    exp_q.push_back('{1'b0, 32'h300, 1'b0, 1'b0, 32'h300, 1'b0});
    step(); pop_check("stall_redir");
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0); stall_i = 1'b0;
    exp_q.push_back('{1'b1, 32'h300, 1'b0, 1'b0, 32'h300, 1'b0});
    step(); pop_check("unstall");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
